dbus_ctrl: RTL and testbench
============================

Name: dbus_ctrl

Overview:
- Memory-stage data-bus controller; sits between the memory-stage datapath (address, size, write data and strobe already formed by the store-formatting logic) and the core's dbus port.
- Accepts one load/store per request, checks alignment, issues a dbus request held stable until completion, and returns raw 64-bit read data.
- Drives the pipeline stall; discards results of flushed requests without abandoning the bus transaction.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data bus width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory stage holds a load/store.
- req_write  in  1  1=store, 0=load.
- req_addr  in  64  byte address.
- req_msize  in  3  msize_t (MSIZE1/2/4/8).
- req_wdata  in  64  lane-aligned store data.
- req_strobe  in  8  byte strobe; ignored for loads.
- flush  in  1  kill current memory-stage instruction.
- out_ready  in  1  pipeline consumes the response this cycle.
- dreq_valid  out  1  dbus request valid.
- dreq_addr  out  64  dbus address.
- dreq_size  out  3  dbus size.
- dreq_strobe  out  8  dbus strobe; 0 for loads.
- dreq_data  out  64  dbus write data.
- dresp_data_ok  in  1  transaction complete.
- dresp_data  in  64  read data.
- resp_valid  out  1  response available.
- resp_rdata  out  64  captured read data; 0 for stores.
- resp_misalign  out  1  response is a misalignment fault; no bus access was made.
- stall  out  1  hold the memory stage.

Behaviour:
- States: IDLE, REQ, DONE, DRAIN.
- Reset, asynchronous: state=IDLE; all registered request fields, resp_rdata and resp_misalign = 0.
- Reset outputs: dreq_valid=0, resp_valid=0, stall=0.
- Misaligned: addr[0]!=0 for MSIZE2; addr[1:0]!=0 for MSIZE4; addr[2:0]!=0 for MSIZE8. MSIZE1 is never misaligned.
- IDLE, req_valid & !flush:
  - Latch addr, msize, write, wdata and strobe (strobe forced to 0 for loads).
  - Aligned: go to REQ.
  - Misaligned: set resp_misalign=1, go to DONE.
- IDLE, flush or !req_valid: stay in IDLE.
- REQ:
  - dreq_valid=1; dreq_* driven only from latched registers and stable until data_ok.
  - On dresp_data_ok: resp_rdata = write ? 0 : dresp_data; go to DONE, or to IDLE if flush in that same cycle.
  - On flush without data_ok: go to DRAIN.
- DRAIN: dreq_valid=1 with unchanged fields; on dresp_data_ok go to IDLE, no response issued.
- DONE:
  - resp_valid=1.
  - out_ready | flush: go to IDLE, clear resp_misalign.
  - Otherwise hold resp_rdata and resp_misalign unchanged.
- No new request is accepted in the cycle DONE exits; next acceptance is the following IDLE cycle.
- Latency: accept at cycle 0; dreq_valid from cycle 1; data_ok at cycle k gives resp_valid at cycle k+1.
  - Zero-wait bus: response at cycle 2.
  - Misaligned request: response at cycle 1.
- stall = (state==IDLE & req_valid & !flush) | state==REQ | state==DRAIN | (state==DONE & !out_ready).
- DRAIN with a new req_valid: stall=1; the new request is accepted only after returning to IDLE.
- Reset mid-transaction: immediately IDLE; the bus side is assumed reset by the same reset.
- dreq_valid is never combinationally dependent on req_* inputs.

Decomposition:
- Shared pipes package: dbus_ctrl_state_t enum {IDLE, REQ, DONE, DRAIN}; reuse existing msize_t and strobe_t from common.
- One combinational sub-module, mem_align_check (inputs addr[2:0] and msize; output misalign), reused later by the load-extension path.

Test Plan:
- Aligned store: addr 0x80000004, MSIZE4, strobe 0xF0, wdata 0x12345678_00000000; data_ok on 3rd REQ cycle.
  - dreq held identical 3 cycles with strobe 0xF0.
  - resp_valid one cycle later, resp_rdata=0.
  - stall drops when out_ready=1.
- Load: addr 0x1008, MSIZE8, zero-wait bus, dresp_data 0xDEADBEEF_CAFEF00D.
  - dreq_valid at cycle 1, dreq_strobe=0.
  - resp_valid at cycle 2 with that data.
- Misaligned: addr 0x1002, MSIZE4.
  - dreq_valid never asserted.
  - resp_valid=1, resp_misalign=1 at cycle 1.
  - Next aligned request: resp_misalign=0.
- Flush in REQ: flush at 2nd REQ cycle; data_ok 3 cycles later.
  - dreq stays asserted through DRAIN.
  - No resp_valid; IDLE after data_ok.
  - A pending new req is accepted the cycle after.
- Backpressure: DONE with out_ready=0 for 4 cycles.
  - resp_valid and resp_rdata stable; stall=1.
  - out_ready=1 returns to IDLE.
- Async reset asserted in REQ mid-cycle: dreq_valid, resp_valid and stall go 0 without a clock edge; state IDLE after release.

Source files
------------

// File: rtl/dbus_ctrl_pkg.sv
// Shared types for the memory-stage data-bus controller and its helpers.
package dbus_ctrl_pkg;

    // Access size, encoded as log2 of the byte count.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } dbus_ctrl_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Natural-alignment check for a memory access; shared with the load-extension path.
module mem_align_check
    import dbus_ctrl_pkg::*;
(
    input  logic [2:0] addr,
    input  msize_t     msize,
    output logic       misalign
);

    // An access is misaligned when any address bit below its size is set.
    always_comb begin
        misalign = 1'b0;
        case (msize)
            MSIZE2:  misalign = addr[0];
            MSIZE4:  misalign = |addr[1:0];
            MSIZE8:  misalign = |addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Memory-stage data-bus controller: accepts one load/store, checks alignment,
// holds a dbus request stable until completion and returns the raw read data.
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2:0]            req_msize,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_strobe,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [2:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_misalign,
    output logic                  stall
);

    localparam int STRB_W = DATA_W / 8;

    dbus_ctrl_state_t    state, state_next;
    logic [ADDR_W-1:0]   addr_q;
    msize_t              msize_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strobe_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                misalign_q;
    logic                misalign;
    logic                accept;

    mem_align_check u_align (
        .addr     (req_addr[2:0]),
        .msize    (msize_t'(req_msize)),
        .misalign (misalign)
    );

    assign accept = (state == IDLE) && req_valid && !flush;

    // State register; reset drops every output-driving state immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and control outputs; bus-side outputs depend on state only.
    always_comb begin
        state_next = state;
        dreq_valid = 1'b0;
        resp_valid = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_next = misalign ? DONE : REQ;
            end
            REQ: begin
                dreq_valid = 1'b1;
                stall      = 1'b1;
                if (dresp_data_ok) state_next = flush ? IDLE : DONE;
                else if (flush)    state_next = DRAIN;
            end
            DRAIN: begin
                // A flushed transaction still has to complete on the bus.
                dreq_valid = 1'b1;
                stall      = 1'b1;
                if (dresp_data_ok) state_next = IDLE;
            end
            DONE: begin
                resp_valid = 1'b1;
                stall      = !out_ready;
                if (out_ready || flush) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields latched on acceptance, response captured on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            msize_q    <= MSIZE1;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strobe_q   <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                msize_q    <= msize_t'(req_msize);
                write_q    <= req_write;
                wdata_q    <= req_wdata;
                strobe_q   <= req_write ? req_strobe : '0;
                rdata_q    <= '0;
                misalign_q <= misalign;
            end
            if ((state == REQ) && dresp_data_ok)
                rdata_q <= write_q ? '0 : dresp_data;
            if ((state == DONE) && (out_ready || flush))
                misalign_q <= 1'b0;
        end
    end

    assign dreq_addr     = addr_q;
    assign dreq_size     = msize_q;
    assign dreq_strobe   = strobe_q;
    assign dreq_data     = wdata_q;
    assign resp_rdata    = rdata_q;
    assign resp_misalign = misalign_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: transaction-level reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_dbus_ctrl;
    import dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [2:0]  req_msize = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strobe = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misalign;
    logic        stall;

    int n_cmp = 0;
    int n_bad = 0;

    dbus_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_msize     (req_msize),
        .req_wdata     (req_wdata),
        .req_strobe    (req_strobe),
        .flush         (flush),
        .out_ready     (out_ready),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding bus transaction (possibly killed) and one pending response.
    bit          m_bus, m_kill, m_resp, m_mis, m_wr;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strb;

    function automatic bit misaligned_f(input logic [63:0] a, input logic [2:0] sz);
        longint unsigned nbytes;
        nbytes = longint'(1) << sz;
        return (a % nbytes) != 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_bus = 0; m_kill = 0; m_resp = 0; m_mis = 0; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_size = '0; m_strb = '0;
        end else if (m_bus) begin
            if (dresp_data_ok) begin
                m_bus = 0;
                if (!m_kill && !flush) begin
                    m_resp  = 1;
                    m_mis   = 0;
                    m_rdata = m_wr ? 64'd0 : dresp_data;
                end
            end else if (flush) begin
                m_kill = 1;
            end
        end else if (m_resp) begin
            if (out_ready || flush) begin
                m_resp = 0;
                m_mis  = 0;
            end
        end else if (req_valid && !flush) begin
            m_addr  = req_addr;
            m_size  = req_msize;
            m_wr    = req_write;
            m_wdata = req_wdata;
            m_strb  = req_write ? req_strobe : 8'h00;
            m_rdata = '0;
            if (misaligned_f(req_addr, req_msize)) begin
                m_resp = 1;
                m_mis  = 1;
            end else begin
                m_bus  = 1;
                m_kill = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = m_bus || (m_resp && !out_ready) ||
                    (!m_bus && !m_resp && req_valid && !flush);
        cmp("m_dreq_valid", {63'd0, dreq_valid}, {63'd0, m_bus});
        cmp("m_resp_valid", {63'd0, resp_valid}, {63'd0, m_resp});
        cmp("m_stall", {63'd0, stall}, {63'd0, exp_stall});
        if (m_bus) begin
            cmp("m_dreq_addr", dreq_addr, m_addr);
            cmp("m_dreq_size", {61'd0, dreq_size}, {61'd0, m_size});
            cmp("m_dreq_strobe", {56'd0, dreq_strobe}, {56'd0, m_strb});
            cmp("m_dreq_data", dreq_data, m_wdata);
        end
        if (m_resp) begin
            cmp("m_resp_rdata", resp_rdata, m_rdata);
            cmp("m_resp_misalign", {63'd0, resp_misalign}, {63'd0, m_mis});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [63:0] a, input logic [2:0] sz,
                             input logic [63:0] wd, input logic [7:0] st);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_msize  = sz;
        req_wdata  = wd;
        req_strobe = st;
    endtask

    initial begin
        repeat (3) cyc();
        settle();
        cmp("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        cmp("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        cmp("rst_stall", {63'd0, stall}, 64'd0);
        cmp("rst_rdata", resp_rdata, 64'd0);
        cmp("rst_misalign", {63'd0, resp_misalign}, 64'd0);
        cyc();
        reset = 1'b0;

        // Aligned store, data_ok on the third REQ cycle
        cyc();
        drive_req(1'b1, 64'h8000_0004, MSIZE4, 64'h1234_5678_0000_0000, 8'hF0);
        settle();
        cmp("st_accept_stall", {63'd0, stall}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            req_valid = 1'b0;
            if (i == 2) begin
                dresp_data_ok = 1'b1;
                dresp_data    = 64'h5555_5555_5555_5555;
            end
            settle();
            cmp("st_dreq_valid", {63'd0, dreq_valid}, 64'd1);
            cmp("st_dreq_addr", dreq_addr, 64'h8000_0004);
            cmp("st_dreq_strobe", {56'd0, dreq_strobe}, 64'hF0);
            cmp("st_dreq_data", dreq_data, 64'h1234_5678_0000_0000);
            cmp("st_resp_valid_early", {63'd0, resp_valid}, 64'd0);
        end
        cyc();
        dresp_data_ok = 1'b0;
        settle();
        cmp("st_resp_valid", {63'd0, resp_valid}, 64'd1);
        cmp("st_resp_rdata", resp_rdata, 64'd0);
        cmp("st_stall_hold", {63'd0, stall}, 64'd1);
        out_ready = 1'b1;
        settle();
        cmp("st_stall_release", {63'd0, stall}, 64'd0);
        cyc();
        out_ready = 1'b0;
        settle();
        cmp("st_idle", {63'd0, resp_valid}, 64'd0);

        // Load on a zero-wait bus; strobe must be suppressed
        cyc();
        drive_req(1'b0, 64'h1008, MSIZE8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        cyc();
        req_valid     = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD_BEEF_CAFE_F00D;
        settle();
        cmp("ld_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        cmp("ld_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
        cmp("ld_dreq_size", {61'd0, dreq_size}, 64'd3);
        cyc();
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        settle();
        cmp("ld_resp_valid", {63'd0, resp_valid}, 64'd1);
        cmp("ld_resp_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Misaligned word access faults without touching the bus
        cyc();
        drive_req(1'b0, 64'h1002, MSIZE4, 64'd0, 8'h00);
        cyc();
        req_valid = 1'b0;
        settle();
        cmp("mis_resp_valid", {63'd0, resp_valid}, 64'd1);
        cmp("mis_flag", {63'd0, resp_misalign}, 64'd1);
        cmp("mis_no_dreq", {63'd0, dreq_valid}, 64'd0);
        cyc();
        settle();
        cmp("mis_flag_hold", {63'd0, resp_misalign}, 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        drive_req(1'b0, 64'h1004, MSIZE4, 64'd0, 8'h00);
        cyc();
        req_valid     = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_0000_0077;
        cyc();
        dresp_data_ok = 1'b0;
        settle();
        cmp("mis_next_valid", {63'd0, resp_valid}, 64'd1);
        cmp("mis_next_flag", {63'd0, resp_misalign}, 64'd0);
        cmp("mis_next_rdata", resp_rdata, 64'h77);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Flush on the second REQ cycle; bus completes three cycles later
        cyc();
        drive_req(1'b0, 64'h2000, MSIZE8, 64'd0, 8'h00);
        cyc();
        req_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive_req(1'b1, 64'h3000, MSIZE1, 64'h0000_0000_0000_00A5, 8'h01);
        settle();
        cmp("fl_drain_dreq", {63'd0, dreq_valid}, 64'd1);
        cmp("fl_drain_addr", dreq_addr, 64'h2000);
        cmp("fl_drain_stall", {63'd0, stall}, 64'd1);
        cyc();
        cyc();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hBAD0_BAD0_BAD0_BAD0;
        settle();
        cmp("fl_drain_last", {63'd0, dreq_valid}, 64'd1);
        cyc();
        dresp_data_ok = 1'b0;
        settle();
        cmp("fl_idle_dreq", {63'd0, dreq_valid}, 64'd0);
        cmp("fl_idle_resp", {63'd0, resp_valid}, 64'd0);
        cmp("fl_idle_stall", {63'd0, stall}, 64'd1);
        cyc();
        req_valid     = 1'b0;
        dresp_data_ok = 1'b1;
        settle();
        cmp("fl_new_addr", dreq_addr, 64'h3000);
        cmp("fl_new_strobe", {56'd0, dreq_strobe}, 64'h01);
        cyc();
        dresp_data_ok = 1'b0;
        settle();
        cmp("fl_new_resp", {63'd0, resp_valid}, 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Backpressure: response held four cycles
        cyc();
        drive_req(1'b0, 64'h40, MSIZE2, 64'd0, 8'h00);
        cyc();
        req_valid     = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 4; i++) begin
            cyc();
            dresp_data_ok = 1'b0;
            dresp_data    = 64'h9999_0000_0000_0000 + 64'(i);
            settle();
            cmp("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            cmp("bp_resp_rdata", resp_rdata, 64'h1111_2222_3333_4444);
            cmp("bp_stall", {63'd0, stall}, 64'd1);
        end
        out_ready = 1'b1;
        settle();
        cmp("bp_release_stall", {63'd0, stall}, 64'd0);
        cyc();
        out_ready = 1'b0;
        settle();
        cmp("bp_idle", {63'd0, resp_valid}, 64'd0);

        // Asynchronous reset in the middle of a REQ cycle
        cyc();
        drive_req(1'b0, 64'h5000, MSIZE8, 64'd0, 8'h00);
        cyc();
        req_valid = 1'b0;
        settle();
        cmp("ar_before", {63'd0, dreq_valid}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        cmp("ar_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        cmp("ar_resp_valid", {63'd0, resp_valid}, 64'd0);
        cmp("ar_stall", {63'd0, stall}, 64'd0);
        cyc();
        reset = 1'b0;
        cyc();
        settle();
        cmp("ar_idle", {63'd0, dreq_valid}, 64'd0);
        drive_req(1'b1, 64'h6000, MSIZE8, 64'h0102_0304_0506_0708, 8'hFF);
        cyc();
        req_valid     = 1'b0;
        dresp_data_ok = 1'b1;
        settle();
        cmp("ar_new_dreq", {63'd0, dreq_valid}, 64'd1);
        cmp("ar_new_data", dreq_data, 64'h0102_0304_0506_0708);
        cyc();
        dresp_data_ok = 1'b0;
        out_ready     = 1'b1;
        settle();
        cmp("ar_new_resp", {63'd0, resp_valid}, 64'd1);
        cyc();
        out_ready = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
